cordic_atan2_ip: RTL

Iterative CORDIC vectoring-mode engine, the inverse of the existing rotation-mode cosine custom instruction.
- Takes a Cartesian vector (x, y) and returns either the angle atan2(y, x) or the gain-corrected magnitude sqrt(x²+y²).
- Sits on the Nios II as a multicycle custom instruction: start/done handshake, dataa/datab in, result out.
- Uses one shared iteration datapath over 16 cycles, not an unrolled pipeline.

---
 rtl/cordic_pkg.sv | 39 +++
 rtl/cordic_vec_stage.sv | 37 +++
 rtl/cordic_atan2_ip.sv | 119 +++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants (Q2.22 angles and gain) for the rotation-mode cosine
// block and the vectoring-mode atan2/magnitude engine.
package cordic_pkg;

   localparam int FRAC         = 22;
   localparam int ANGLE_W      = 24;
   localparam int ATAN_ENTRIES = 16;

   localparam logic [ANGLE_W-1:0] K_FIXED = 24'h26DD3B;
   localparam logic [ANGLE_W-1:0] HALF_PI = 24'h6487ED;
   localparam logic [ANGLE_W-1:0] PI      = 24'hC90FDB;

   // Rotation-mode cosine block start vector: x0 = K so the output needs no rescale.
   localparam logic [ANGLE_W-1:0] COS_X_INIT = K_FIXED;
   localparam logic [ANGLE_W-1:0] COS_Y_INIT = 24'h000000;

   localparam logic [ANGLE_W-1:0] ATAN_TABLE [ATAN_ENTRIES] = '{
      24'h3243F6, 24'h1DAC68, 24'h0FADBB, 24'h07F56F,
      24'h03FEAB, 24'h01FFD5, 24'h00FFFB, 24'h007FFF,
      24'h004000, 24'h002000, 24'h001000, 24'h000800,
      24'h000400, 24'h000200, 24'h000100, 24'h000080
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_SCALE,
      ST_DONE
   } state_t;

   // Beyond the table atan(2^-i) equals 2^-i to within one LSB.
   function automatic logic [ANGLE_W-1:0] atan_lut(input logic [4:0] i);
      if (i < 5'(ATAN_ENTRIES))
         atan_lut = ATAN_TABLE[i[3:0]];
      else
         atan_lut = 24'h1 << (5'd22 - i);
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode micro-rotation: drives y toward zero and accumulates the
// rotated angle in z.
module cordic_vec_stage
   import cordic_pkg::*;
#(
   parameter int IW = 26
)
(
   input  logic signed [IW-1:0] x,
   input  logic signed [IW-1:0] y,
   input  logic signed [IW-1:0] z,
   input  logic        [4:0]    i,
   output logic signed [IW-1:0] x_next,
   output logic signed [IW-1:0] y_next,
   output logic signed [IW-1:0] z_next
);

   logic signed [IW-1:0] x_shift;
   logic signed [IW-1:0] y_shift;
   logic signed [IW-1:0] atan_ext;

   always_comb begin
      x_shift  = x >>> i;
      y_shift  = y >>> i;
      atan_ext = {{(IW-ANGLE_W){1'b0}}, atan_lut(i)};
      if (!y[IW-1]) begin
         x_next = x + y_shift;
         y_next = y - x_shift;
         z_next = z + atan_ext;
      end else begin
         x_next = x - y_shift;
         y_next = y + x_shift;
         z_next = z - atan_ext;
      end
   end

endmodule

// File: rtl/cordic_atan2_ip.sv
// Multicycle custom instruction: atan2(y, x) or sqrt(x^2+y^2) via an iterative
// vectoring CORDIC sharing one micro-rotation stage.
module cordic_atan2_ip
   import cordic_pkg::*;
#(
   parameter int CORDIC_STAGES = 16,
   parameter int IW            = 26
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   input  logic        n,
   output logic [31:0] result,
   output logic        done
);

   localparam logic [4:0] LAST_ITER = 5'(CORDIC_STAGES - 1);

   state_t               state_reg;
   logic signed [IW-1:0] x_reg, y_reg, z_reg;
   logic signed [IW-1:0] x_next, y_next, z_next;
   logic        [4:0]    iter_reg;
   logic                 n_reg, zero_reg, done_reg;
   logic        [31:0]   result_reg;

   logic signed [IW-1:0]    x_in, y_in, x_load, y_load, z_load;
   logic signed [IW+23:0]   prod;
   logic signed [IW-1:0]    mag, sel;
   logic                    unused_bits;

   cordic_vec_stage #(.IW(IW)) u_stage (
      .x      (x_reg),
      .y      (y_reg),
      .z      (z_reg),
      .i      (iter_reg),
      .x_next (x_next),
      .y_next (y_next),
      .z_next (z_next)
   );

   // Quadrant pre-rotation keeps the working vector in the right half-plane.
   always_comb begin
      x_in = {{(IW-24){dataa[23]}}, dataa[23:0]};
      y_in = {{(IW-24){datab[23]}}, datab[23:0]};
      if (!x_in[IW-1]) begin
         x_load = x_in;
         y_load = y_in;
         z_load = '0;
      end else if (!y_in[IW-1]) begin
         x_load = y_in;
         y_load = -x_in;
         z_load = {{(IW-ANGLE_W){1'b0}}, HALF_PI};
      end else begin
         x_load = -y_in;
         y_load = x_in;
         z_load = -{{(IW-ANGLE_W){1'b0}}, HALF_PI};
      end
   end

   assign prod        = x_reg * $signed(K_FIXED);
   assign mag         = prod[FRAC +: IW];
   assign sel         = n_reg ? mag : z_reg;
   assign unused_bits = &{1'b0, dataa[31:24], datab[31:24],
                          prod[FRAC-1:0], prod[IW+23:IW+FRAC]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         x_reg      <= '0;
         y_reg      <= '0;
         z_reg      <= '0;
         iter_reg   <= '0;
         n_reg      <= 1'b0;
         zero_reg   <= 1'b0;
         done_reg   <= 1'b0;
         result_reg <= '0;
      end else if (clk_en) begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  x_reg     <= x_load;
                  y_reg     <= y_load;
                  z_reg     <= z_load;
                  iter_reg  <= '0;
                  n_reg     <= n;
                  zero_reg  <= (x_in == '0) && (y_in == '0);
                  state_reg <= ST_ITER;
               end
            end
            ST_ITER: begin
               x_reg <= x_next;
               y_reg <= y_next;
               z_reg <= z_next;
               if (iter_reg == LAST_ITER)
                  state_reg <= ST_SCALE;
               else
                  iter_reg <= iter_reg + 5'd1;
            end
            ST_SCALE: begin
               // A zero vector has no direction; the unchecked z would be the table sum.
               result_reg <= zero_reg ? '0 : {{(32-IW){sel[IW-1]}}, sel};
               done_reg   <= 1'b1;
               state_reg  <= ST_DONE;
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign result = result_reg;
   assign done   = done_reg & clk_en;

endmodule
